// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

  localparam int DW    = 64;
  localparam int BE_W  = DW / 8;
  localparam int OFF_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic             store,
  input  logic [DW-1:0]    store_data,
  input  logic [DW-1:0]    rdata,
  output logic [BE_W-1:0]  be,
  output logic [DW-1:0]    wdata,
  output logic             misaligned,
  output logic             illegal,
  output logic [DW-1:0]    load_data
);

  logic [DW-1:0] shifted;
  logic [DW-1:0] field;

  always_comb begin
    be         = '0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: be = 8'h01 << off;
      2'b01: begin
        be         = 8'h03 << off;
        misaligned = off[0];
      end
      2'b10: begin
        be         = 8'h0F << off;
        misaligned = |off[1:0];
      end
      default: begin
        be         = 8'hFF;
        misaligned = |off;
      end
    endcase
    illegal = store ? funct3[2] : (funct3 == 3'b111);
  end

  // lanes outside the enabled bytes are forced to zero
  always_comb begin
    shifted = store_data << {off, 3'b000};
    wdata   = '0;
    for (int i = 0; i < BE_W; i++) begin
      wdata[8*i +: 8] = be[i] ? shifted[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    field     = rdata >> {off, 3'b000};
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{56{field[7]}},  field[7:0]};
      F3_H:    load_data = {{48{field[15]}}, field[15:0]};
      F3_W:    load_data = {{32{field[31]}}, field[31:0]};
      F3_D:    load_data = field;
      F3_BU:   load_data = {56'd0, field[7:0]};
      F3_HU:   load_data = {48'd0, field[15:0]};
      F3_WU:   load_data = {32'd0, field[31:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: request/ack data-memory port with timeout and
// write-back formatting.
//
//   state | meaning
//   IDLE  | ready for a request; decode and either respond or start access
//   BUSY  | dmem_req held, waiting for dmem_ack or timeout
//   RESP  | resp_valid pulse, wb_data/resp_err valid
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  output logic            resp_valid,
  output logic [XLEN-1:0] wb_data,
  output logic            resp_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [7:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state;
  logic [XLEN-1:0] alu_q;
  logic [2:0]      f3_q;
  logic            m2r_q;
  logic [CW-1:0]   cnt;

  logic [2:0]      a_f3;
  logic [2:0]      a_off;
  logic            a_store;
  logic [7:0]      a_be;
  logic [XLEN-1:0] a_wdata;
  logic            a_misaligned;
  logic            a_illegal;
  logic [XLEN-1:0] a_load;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // live request fields while deciding, captured ones while formatting the load
  assign a_f3    = (state == IDLE) ? funct3           : f3_q;
  assign a_off   = (state == IDLE) ? alu_result[2:0]  : alu_q[2:0];
  assign a_store = (state == IDLE) ? mem_write        : dmem_we;

  load_store_align u_align (
    .funct3     (a_f3),
    .off        (a_off),
    .store      (a_store),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (a_be),
    .wdata      (a_wdata),
    .misaligned (a_misaligned),
    .illegal    (a_illegal),
    .load_data  (a_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      alu_q      <= '0;
      f3_q       <= '0;
      m2r_q      <= 1'b0;
      cnt        <= '0;
      wb_data    <= '0;
      resp_err   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_q <= alu_result;
            f3_q  <= funct3;
            m2r_q <= mem_to_reg;
            if (mem_read && mem_write) begin
              state    <= RESP;
              resp_err <= 1'b1;
              wb_data  <= '0;
            end else if (!mem_read && !mem_write) begin
              state    <= RESP;
              resp_err <= 1'b0;
              wb_data  <= alu_result;
            end else if (a_illegal || a_misaligned) begin
              state    <= RESP;
              resp_err <= 1'b1;
              wb_data  <= '0;
            end else begin
              state      <= BUSY;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_result[XLEN-1:3], 3'b000};
              dmem_be    <= a_be;
              dmem_wdata <= a_wdata;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state      <= RESP;
            resp_err   <= 1'b0;
            wb_data    <= (!dmem_we && m2r_q) ? a_load : alu_q;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
              state      <= RESP;
              resp_err   <= 1'b1;
              wb_data    <= '0;
              dmem_req   <= 1'b0;
              dmem_we    <= 1'b0;
              dmem_addr  <= '0;
              dmem_be    <= '0;
              dmem_wdata <= '0;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed checks of mem_access_unit with a 4-cycle ack timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic        mem_read, mem_write, mem_to_reg;
  logic [2:0]  funct3;
  logic [63:0] alu_result, store_data;
  logic        resp_valid, resp_err;
  logic [63:0] wb_data;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .resp_valid (resp_valid),
    .wb_data    (wb_data),
    .resp_err   (resp_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // present one request for a single cycle; returns on the negedge after accept
  task automatic issue(input logic rd, input logic wr, input logic m2r,
                       input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] sd);
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    mem_to_reg = m2r;
    funct3     = f3;
    alu_result = alu;
    store_data = sd;
    nclk();
    req_valid  = 1'b0;
  endtask

  initial begin
    int reqs;
    reset = 1'b1; req_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    funct3 = 0; alu_result = 0; store_data = 0; dmem_ack = 0; dmem_rdata = 0;
    nclk(); nclk();
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_wb", wb_data, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    reset = 1'b0;
    nclk();

    // SD, ack on third BUSY cycle
    issue(0, 1, 0, 3'b011, 64'h1000, 64'h1122334455667788);
    chk("sd_req1", dmem_req, 1);
    chk("sd_addr", dmem_addr, 64'h1000);
    chk("sd_be", dmem_be, 8'hFF);
    chk("sd_we", dmem_we, 1);
    chk("sd_wdata", dmem_wdata, 64'h1122334455667788);
    chk("sd_ready_low", req_ready, 0);
    nclk();
    chk("sd_req2", dmem_req, 1);
    chk("sd_no_resp2", resp_valid, 0);
    nclk();
    chk("sd_req3", dmem_req, 1);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("sd_resp", resp_valid, 1);
    chk("sd_req_drop", dmem_req, 0);
    chk("sd_err", resp_err, 0);
    chk("sd_wb", wb_data, 64'h1000);
    nclk();
    chk("sd_resp_pulse", resp_valid, 0);
    chk("sd_ready", req_ready, 1);

    // SB at 0x2005, ack on first BUSY cycle
    issue(0, 1, 0, 3'b000, 64'h2005, 64'hAB);
    chk("sb_be", dmem_be, 8'h20);
    chk("sb_wdata", dmem_wdata, 64'h0000AB0000000000);
    chk("sb_addr", dmem_addr, 64'h2000);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("sb_resp", resp_valid, 1);
    chk("sb_wb", wb_data, 64'h2005);
    nclk();

    // SH at 0x2002: lanes 2,3 only, upper store bits masked off
    issue(0, 1, 0, 3'b001, 64'h2002, 64'h1234BEEF);
    chk("sh_be", dmem_be, 8'h0C);
    chk("sh_wdata", dmem_wdata, 64'h00000000BEEF0000);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    nclk();

    // LB / LBU at 0x2005
    dmem_rdata = 64'h1122AB4455667788;
    issue(1, 0, 1, 3'b000, 64'h2005, 0);
    chk("lb_we", dmem_we, 0);
    chk("lb_be", dmem_be, 8'h20);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("lb_resp", resp_valid, 1);
    chk("lb_wb", wb_data, 64'hFFFFFFFFFFFFFFAB);
    chk("lb_err", resp_err, 0);
    nclk();
    issue(1, 0, 1, 3'b100, 64'h2005, 0);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("lbu_wb", wb_data, 64'hAB);
    nclk();

    // LW / LWU of upper word, and load with mem_to_reg=0
    dmem_rdata = 64'h8000000112345678;
    issue(1, 0, 1, 3'b010, 64'h3004, 0);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("lw_wb", wb_data, 64'hFFFFFFFF80000001);
    nclk();
    issue(1, 0, 1, 3'b110, 64'h3004, 0);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("lwu_wb", wb_data, 64'h0000000080000001);
    nclk();
    issue(1, 0, 0, 3'b010, 64'h3004, 0);
    dmem_ack = 1'b1;
    nclk();
    dmem_ack = 1'b0;
    chk("lw_nom2r_wb", wb_data, 64'h3004);
    nclk();

    // misaligned LW, illegal load funct3, read+write conflict
    issue(1, 0, 1, 3'b010, 64'h3002, 0);
    chk("mis_no_req", dmem_req, 0);
    chk("mis_resp", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    nclk();
    issue(1, 0, 1, 3'b111, 64'h3000, 0);
    chk("ill_no_req", dmem_req, 0);
    chk("ill_resp", resp_valid, 1);
    chk("ill_err", resp_err, 1);
    nclk();
    issue(1, 1, 0, 3'b011, 64'h3000, 0);
    chk("rw_resp", resp_valid, 1);
    chk("rw_err", resp_err, 1);
    nclk();

    // non-memory pass-through
    chk("nm_ready_before", req_ready, 1);
    issue(0, 0, 0, 3'b000, 64'h42, 0);
    chk("nm_resp", resp_valid, 1);
    chk("nm_wb", wb_data, 64'h42);
    chk("nm_err", resp_err, 0);
    chk("nm_ready_low", req_ready, 0);
    chk("nm_no_req", dmem_req, 0);
    nclk();
    chk("nm_ready_after", req_ready, 1);
    chk("nm_resp_pulse", resp_valid, 0);

    // LD timeout after 4 BUSY cycles, late ack ignored
    issue(1, 0, 1, 3'b011, 64'h4000, 0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) break;
      if (dmem_req) reqs++;
      nclk();
    end
    chk("to_req_cycles", 64'(reqs), 4);
    chk("to_resp", resp_valid, 1);
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", resp_err, 1);
    chk("to_wb", wb_data, 0);
    dmem_ack = 1'b1;
    nclk();
    chk("to_late_no_resp", resp_valid, 0);
    chk("to_late_no_req", dmem_req, 0);
    chk("to_err_hold", resp_err, 1);
    nclk();
    dmem_ack = 1'b0;
    chk("to_late_no_resp2", resp_valid, 0);
    chk("to_ready", req_ready, 1);

    // reset asserted mid-access
    issue(1, 0, 1, 3'b011, 64'h5000, 0);
    chk("rb_busy_req", dmem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rb_req_now", dmem_req, 0);
    chk("rb_resp_now", resp_valid, 0);
    chk("rb_ready_now", req_ready, 1);
    nclk();
    reset = 1'b0;
    dmem_ack = 1'b1;
    nclk();
    chk("rb_ack_no_resp", resp_valid, 0);
    dmem_ack = 1'b0;
    nclk();
    chk("rb_ack_no_resp2", resp_valid, 0);
    chk("rb_no_req", dmem_req, 0);
    chk("rb_wb", wb_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access stage directly downstream of the ALU. Consumes the ALU result as an effective address, plus rs2 data and the control-unit signals mem_read, mem_write and mem_to_reg.
- Performs byte/half/word/doubleword loads and stores over a request/acknowledge data-memory port.
- Returns the write-back value (formatted load data or ALU result) to the register file.
- Multi-cycle. The PC/regfile are held while req_ready is low.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.
- TIMEOUT, 255, maximum cycles to wait for dmem_ack before aborting with an error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- mem_to_reg  in  1  1: write back load data; 0: write back alu_result.
- funct3  in  3  access size/sign, instruction[14:12].
- alu_result  in  XLEN  effective address / pass-through value.
- store_data  in  XLEN  rs2 data.
- resp_valid  out  1  one-cycle pulse: wb_data and resp_err are valid.
- wb_data  out  XLEN  write-back value.
- resp_err  out  1  misaligned, illegal or timed-out access.
- dmem_req  out  1  memory request; held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  {addr[63:3],3'b000}.
- dmem_be  out  8  byte enables.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_ack  in  1  memory done; rdata valid on reads.
- dmem_rdata  in  XLEN  aligned doubleword read data.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, wb_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, timeout counter=0.
  - Reset mid-access drops dmem_req immediately. A dmem_ack arriving later in IDLE is ignored.
- States: IDLE, BUSY, RESP.
- IDLE, on accept, captures every request input. Next state:
  - mem_read & mem_write both set -> RESP, err=1.
  - Neither set -> RESP, wb_data=alu_result, err=0 (1-cycle latency, no dmem traffic).
  - Illegal funct3 (load 3'b111; store funct3[2]=1) -> RESP, err=1.
  - Misaligned address (half: addr[0]≠0; word: addr[1:0]≠0; double: addr[2:0]≠0) -> RESP, err=1, no dmem_req.
  - Otherwise -> BUSY, with registered dmem_* driven from the next cycle.
- BUSY:
  - dmem_req=1, with dmem_addr/we/be/wdata stable until ack.
  - On dmem_ack:
    - Read: wb_data = mem_to_reg ? formatted load : alu_result.
    - Write: wb_data = alu_result.
    - Then err=0, dmem_req drops, go to RESP.
  - The counter increments each BUSY cycle without ack. If TIMEOUT≠0 and counter reaches TIMEOUT: abort, dmem_req=0, err=1, wb_data=0, go to RESP. The counter clears on BUSY entry.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. wb_data and resp_err hold until the next response.
- Latency: non-memory request 1 cycle. Memory access = 2 + (cycles until ack). An ack present on the first BUSY cycle gives resp_valid two cycles after accept.
- Byte lane off=addr[2:0].
  - Byte enables: SB 8'b1<<off; SH 8'b11<<off; SW 8'hF<<off; SD 8'hFF.
  - dmem_wdata = store_data<<(8*off); bits outside the enabled lanes are don't-care, driven 0.
- Load formatting: field = dmem_rdata>>(8*off).
  - LB/LH/LW (000/001/010) sign-extend 8/16/32 bits.
  - LD (011) takes the full 64 bits.
  - LBU/LHU/LWU (100/101/110) zero-extend.
- dmem_ack outside BUSY is ignored. req_valid outside IDLE is not accepted.

Decomposition:
- Shared package mem_pkg: state enum {IDLE,BUSY,RESP}; funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU; width localparams.
- One combinational sub-module, load_store_align: computes be, wdata, misaligned and illegal flags, and the formatted load value from (funct3, off, store_data, rdata).
- The FSM, counter and registers live in mem_access_unit.

Test Plan:
- SD at alu_result=0x1000, store_data=0x1122334455667788, ack on the 3rd BUSY cycle. Require: dmem_addr=0x1000, be=8'hFF, we=1, dmem_req high 3 cycles, resp_valid 1 cycle later, err=0, wb_data=0x1000.
- SB at 0x2005, store_data=0xAB, ack on the first BUSY cycle. Require: be=8'h20, wdata[47:40]=0xAB, dmem_addr=0x2000. LB at 0x2005 with rdata byte5=0xAB gives wb_data=0xFFFFFFFFFFFFFFAB; LBU gives 0xAB.
- LW at 0x3002 (misaligned). Require: no dmem_req, resp_valid the next cycle, err=1. Also load funct3=3'b111 gives err=1.
- Non-memory request, alu_result=0x42, mem_read=mem_write=0. Require: resp_valid the next cycle, wb_data=0x42, req_ready low only for that cycle.
- LD with no ack and TIMEOUT=4. Require: dmem_req high 4 cycles, then deasserts; resp_valid with err=1, wb_data=0; a late ack is ignored.
- Assert reset while in BUSY. Require: dmem_req and resp_valid 0 immediately (same cycle), req_ready=1, and a subsequent ack produces no response.
